// File: rtl/fft_frame_tx.sv
// Frame buffer feeding a streaming FFT: fill, burst out, time the result.
// Define FFT_FRAME_TX_LATCHK_EN to enable the WAIT timeout check.
module fft_frame_tx #(
  parameter int FFT_SIZE  = 32,
  parameter int IN_WIDTH  = 12,
  parameter int LAT_LIMIT = 68
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_r,
  input  logic [IN_WIDTH-1:0] s_i,
  output logic                in_valid,
  output logic [IN_WIDTH-1:0] din_r,
  output logic [IN_WIDTH-1:0] din_i,
  input  logic                out_valid,
  output logic                frame_done,
  output logic [7:0]          latency,
  output logic                timeout
);

  localparam int AW = $clog2(FFT_SIZE);
  localparam logic [AW-1:0] LAST = AW'(FFT_SIZE - 1);
  localparam logic [8:0] LIM = 9'(LAT_LIMIT);
`ifdef FFT_FRAME_TX_LATCHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [AW-1:0]       out_q, out_d;
  logic [7:0]          lat_q, lat_d;
  logic                vld_q, vld_d;
  logic [IN_WIDTH-1:0] dr_q, dr_d;
  logic [IN_WIDTH-1:0] di_q, di_d;
  logic                done_q, done_d;
  logic [7:0]          latency_q, latency_d;
  logic                tmo_q, tmo_d;

  logic [IN_WIDTH-1:0] mem_r_q [FFT_SIZE];
  logic [IN_WIDTH-1:0] mem_i_q [FFT_SIZE];

  logic          acc;
  logic [AW-1:0] rd_nx;
  logic [7:0]    lat_inc;

  assign acc     = (state_q == FILL) && s_valid;
  assign rd_nx   = rd_q + 1'b1;
  assign lat_inc = (lat_q == 8'hFF) ? lat_q : lat_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    out_d     = out_q;
    lat_d     = lat_q;
    vld_d     = 1'b0;
    dr_d      = '0;
    di_d      = '0;
    done_d    = 1'b0;
    latency_d = latency_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          if (wr_q == LAST) begin
            state_d = SEND;
            wr_d    = '0;
            rd_d    = '0;
            vld_d   = 1'b1;
            dr_d    = mem_r_q[0];
            di_d    = mem_i_q[0];
            tmo_d   = 1'b0;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (rd_q == LAST) begin
          state_d = WAIT;
          lat_d   = '0;
        end else begin
          rd_d  = rd_nx;
          vld_d = 1'b1;
          dr_d  = mem_r_q[rd_nx];
          di_d  = mem_i_q[rd_nx];
        end
      end
      WAIT: begin
        if (out_valid) begin
          latency_d = lat_q;
          out_d     = AW'(1);
          state_d   = DRAIN;
        end else begin
          lat_d = lat_inc;
          // Give up on a stalled FFT without reporting a frame
          if (CHK && ({1'b0, lat_inc} > LIM)) begin
            tmo_d     = 1'b1;
            latency_d = lat_inc;
            lat_d     = '0;
            state_d   = FILL;
          end
        end
      end
      DRAIN: begin
        if (out_valid) begin
          if (out_q == LAST) begin
            done_d  = 1'b1;
            out_d   = '0;
            state_d = FILL;
          end else begin
            out_d = out_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_q      <= '0;
      rd_q      <= '0;
      out_q     <= '0;
      lat_q     <= '0;
      vld_q     <= 1'b0;
      dr_q      <= '0;
      di_q      <= '0;
      done_q    <= 1'b0;
      latency_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      out_q     <= out_d;
      lat_q     <= lat_d;
      vld_q     <= vld_d;
      dr_q      <= dr_d;
      di_q      <= di_d;
      done_q    <= done_d;
      latency_q <= latency_d;
      tmo_q     <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      mem_r_q[wr_q] <= s_r;
      mem_i_q[wr_q] <= s_i;
    end
  end

  assign s_ready    = (state_q == FILL);
  assign in_valid   = vld_q;
  assign din_r      = dr_q;
  assign din_i      = di_q;
  assign frame_done = done_q;
  assign latency    = latency_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Directed bench for fft_frame_tx: fill, send, latency, drain, timeout, reset.
// Build with FFT_FRAME_TX_LATCHK_EN to exercise the timeout path.
module tb_fft_frame_tx;

  localparam int N = 32;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_r;
  logic [W-1:0] s_i;
  logic         in_valid;
  logic [W-1:0] din_r;
  logic [W-1:0] din_i;
  logic         out_valid;
  logic         frame_done;
  logic [7:0]   latency;
  logic         timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fft_frame_tx #(.FFT_SIZE(N), .IN_WIDTH(W), .LAT_LIMIT(68)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_r(s_r), .s_i(s_i),
    .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .frame_done(frame_done),
    .latency(latency), .timeout(timeout)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill(input int base, input bit gap);
    for (int j = 0; j < N; j++) begin
      s_valid = 1'b1;
      s_r = W'(base + j);
      s_i = W'(-(base + j));
      tick();
      if (gap && j != N - 1) begin
        s_valid = 1'b0;
        s_r = W'(12'h7AA);
        s_i = W'(12'h555);
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    out_valid = 1'b1;
    repeat (N) tick();
    out_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; out_valid = 1'b0;
    s_r = '0; s_i = '0;
    tick(); tick();
    n_chk++;
    if (s_ready !== 1'b1 || in_valid !== 1'b0 || din_r !== '0 ||
        din_i !== '0 || frame_done !== 1'b0 || latency !== 8'd0 ||
        timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b iv=%b dr=%0d di=%0d fd=%b lat=%0d to=%b, expected 1 0 0 0 0 0 0",
               s_ready, in_valid, din_r, din_i, frame_done, latency, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    fill(0, 1'b0);
    s_valid = 1'b1; s_r = W'(12'h3C3); s_i = W'(12'h3C3);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (in_valid !== 1'b1 || din_r !== W'(k) || din_i !== W'(-k)) begin
        n_fail++;
        $display("FAIL fill_send[%0d]: iv=%b dr=%0d di=%0d, expected 1 %0d %0d",
                 k, in_valid, din_r, din_i, W'(k), W'(-k));
      end
      tick();
    end
    s_valid = 1'b0;
    n_chk++;
    if (in_valid !== 1'b0 || din_r !== '0 || din_i !== '0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_end: iv=%b dr=%0d di=%0d rdy=%b, expected 0 0 0 0",
               in_valid, din_r, din_i, s_ready);
    end
    drain();
  endtask

  task automatic test_gapped_input();
    fill(0, 1'b1);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (in_valid !== 1'b1 || din_r !== W'(k) || din_i !== W'(-k)) begin
        n_fail++;
        $display("FAIL gap_send[%0d]: iv=%b dr=%0d di=%0d, expected 1 %0d %0d",
                 k, in_valid, din_r, din_i, W'(k), W'(-k));
      end
      tick();
    end
    n_chk++;
    if (in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_end: iv=%b, expected 0", in_valid);
    end
    drain();
  endtask

  task automatic test_latency();
    fill(200, 1'b0);
    repeat (N) tick();
    n_chk++;
    if (in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_wait_entry: iv=%b, expected 0", in_valid);
    end
    repeat (20) tick();
    out_valid = 1'b1;
    for (int k = 1; k <= N; k++) begin
      tick();
      n_chk++;
      if (frame_done !== (k == N)) begin
        n_fail++;
        $display("FAIL lat_done[%0d]: frame_done=%b, expected %b", k, frame_done, k == N);
      end
      if (k == 1) begin
        n_chk++;
        if (latency !== 8'd20 || s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_first: latency=%0d rdy=%b, expected 20 0", latency, s_ready);
        end
      end
    end
    n_chk++;
    if (s_ready !== 1'b1 || latency !== 8'd20) begin
      n_fail++;
      $display("FAIL lat_end: rdy=%b latency=%0d, expected 1 20", s_ready, latency);
    end
    out_valid = 1'b0;
    tick();
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_pulse: frame_done=%b, expected 0", frame_done);
    end
  endtask

  task automatic test_gapped_output();
    out_valid = 1'b1;
    fill(50, 1'b0);
    repeat (N) tick();
    out_valid = 1'b0;
    repeat (5) tick();
    for (int k = 1; k <= N; k++) begin
      out_valid = 1'b1;
      tick();
      n_chk++;
      if (frame_done !== (k == N)) begin
        n_fail++;
        $display("FAIL gout_pulse[%0d]: frame_done=%b, expected %b", k, frame_done, k == N);
      end
      out_valid = 1'b0;
      tick();
      n_chk++;
      if (frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL gout_gap[%0d]: frame_done=%b, expected 0", k, frame_done);
      end
    end
    n_chk++;
    if (s_ready !== 1'b1 || latency !== 8'd5) begin
      n_fail++;
      $display("FAIL gout_end: rdy=%b latency=%0d, expected 1 5", s_ready, latency);
    end
  endtask

  task automatic test_timeout();
    fill(300, 1'b0);
    repeat (N) tick();
    repeat (68) tick();
    n_chk++;
    if (timeout !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL to_before: timeout=%b rdy=%b, expected 0 0", timeout, s_ready);
    end
    tick();
`ifdef FFT_FRAME_TX_LATCHK_EN
    n_chk++;
    if (timeout !== 1'b1 || s_ready !== 1'b1 || frame_done !== 1'b0 || latency !== 8'd69) begin
      n_fail++;
      $display("FAIL to_fire: timeout=%b rdy=%b fd=%b lat=%0d, expected 1 1 0 69",
               timeout, s_ready, frame_done, latency);
    end
    repeat (3) tick();
    n_chk++;
    if (timeout !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky: timeout=%b fd=%b, expected 1 0", timeout, frame_done);
    end
    fill(0, 1'b0);
    n_chk++;
    if (timeout !== 1'b0 || in_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_clear: timeout=%b iv=%b, expected 0 1", timeout, in_valid);
    end
    repeat (N) tick();
    drain();
`else
    n_chk++;
    if (timeout !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL to_off: timeout=%b rdy=%b, expected 0 0", timeout, s_ready);
    end
    repeat (300) tick();
    n_chk++;
    if (timeout !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL to_off_long: timeout=%b rdy=%b, expected 0 0", timeout, s_ready);
    end
    out_valid = 1'b1;
    repeat (N) tick();
    out_valid = 1'b0;
    n_chk++;
    if (latency !== 8'd255 || frame_done !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_sat: latency=%0d fd=%b rdy=%b, expected 255 1 1",
               latency, frame_done, s_ready);
    end
    tick();
`endif
  endtask

  task automatic test_reset_in_send();
    fill(400, 1'b0);
    repeat (9) tick();
    n_chk++;
    if (in_valid !== 1'b1 || din_r !== W'(409)) begin
      n_fail++;
      $display("FAIL rs_send10: iv=%b dr=%0d, expected 1 409", in_valid, din_r);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (in_valid !== 1'b0 || s_ready !== 1'b1 || latency !== 8'd0 ||
        din_r !== '0 || din_i !== '0) begin
      n_fail++;
      $display("FAIL rs_after: iv=%b rdy=%b lat=%0d dr=%0d di=%0d, expected 0 1 0 0 0",
               in_valid, s_ready, latency, din_r, din_i);
    end
    fill(500, 1'b0);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (in_valid !== 1'b1 || din_r !== W'(500 + k) || din_i !== W'(-(500 + k))) begin
        n_fail++;
        $display("FAIL rs_send[%0d]: iv=%b dr=%0d di=%0d, expected 1 %0d %0d",
                 k, in_valid, din_r, din_i, W'(500 + k), W'(-(500 + k)));
      end
      tick();
    end
    n_chk++;
    if (in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_end: iv=%b, expected 0", in_valid);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gapped_input();
    test_latency();
    test_gapped_output();
    test_timeout();
    test_reset_in_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
